mcycle_muldiv: RTL

- Parametrised multi-cycle multiply/divide unit. Successor to the current single-mode shift-add MCycle.
- Adds signed and unsigned modes, full double-width product, and simultaneous quotient and remainder.
- Adds a generic destination tag and a divide-by-zero flag.
- Sits beside the ALU in the execute stage. The pipeline stalls on Busy and writes Result/ResultHi to the register named by TagOut when Done pulses.

---
 rtl/mcycle_muldiv.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mcycle_muldiv.sv
// Multi-cycle multiply/divide unit: signed/unsigned shift-add multiply with a
// double-width product, and restoring divide giving quotient and remainder.
// Optional feature macro: MCYCLE_EARLY_OUT_EN lets zero-operand multiplies
// and divide-by-zero skip the iteration phase.
module mcycle_muldiv #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  input  logic [TAG_W-1:0] TagIn,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] ResultHi,
  output logic             Busy,
  output logic             Done,
  output logic [TAG_W-1:0] TagOut,
  output logic             DivByZero
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic start_accept, finish, early;

  // Operation context captured at Start
  logic is_div_q, neg_res_q, neg_rem_q, dbz_q;
  // hi_q: product high / partial remainder; lo_q: multiplier / dividend->quotient
  logic [WIDTH-1:0] hi_q, lo_q, opb_q;
  logic [WIDTH-1:0] result_q, result_hi_q;
  logic [TAG_W-1:0] tag_q;
  logic dbz_out_q;

  // Capture-side decode
  logic in_div, in_sgn, in_dbz, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  // Iteration and sign fix-up
  logic [WIDTH:0] mul_sum, div_shift, div_diff;
  logic div_ok;
  logic [WIDTH-1:0] iter_hi, iter_lo, fix_hi, fix_lo;
  logic [2*WIDTH-1:0] prod, prod_neg;

  assign in_div = Op[1];
  assign in_sgn = Op[0];
  assign in_dbz = in_div && (Operand2 == '0);

`ifdef MCYCLE_EARLY_OUT_EN
  assign early = in_div ? in_dbz : ((Operand1 == '0) || (Operand2 == '0));
`else
  assign early = 1'b0;
`endif

  // Magnitudes and signs; divide-by-zero keeps the raw dividend so it comes out unmodified
  always_comb begin
    a_neg = in_sgn && !in_dbz && Operand1[WIDTH-1];
    b_neg = in_sgn && !in_dbz && Operand2[WIDTH-1];
    a_mag = a_neg ? -Operand1 : Operand1;
    b_mag = b_neg ? -Operand2 : Operand2;
  end

  // One multiply or restoring-divide step, plus the fix-up applied on the last step
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    div_ok    = ~div_diff[WIDTH];
    if (is_div_q) begin
      iter_hi = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      iter_lo = {lo_q[WIDTH-2:0], div_ok};
    end else begin
      iter_hi = mul_sum[WIDTH:1];
      iter_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
    prod     = {iter_hi, iter_lo};
    prod_neg = -prod;
    if (is_div_q) begin
      fix_lo = neg_res_q ? -iter_lo : iter_lo;
      fix_hi = neg_rem_q ? -iter_hi : iter_hi;
    end else begin
      fix_lo = neg_res_q ? prod_neg[WIDTH-1:0] : iter_lo;
      fix_hi = neg_res_q ? prod_neg[2*WIDTH-1:WIDTH] : iter_hi;
    end
  end

  // Next-state logic; DONE accepts a new Start just like IDLE
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    start_accept = 1'b0;
    finish       = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (Start) begin
          start_accept = 1'b1;
          cnt_d        = '0;
          state_d      = early ? StDone : StRun;
        end
      end
      StRun: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          finish  = 1'b1;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Datapath: capture on Start, iterate in RUN, latch fixed-up results on the last step
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      is_div_q    <= 1'b0;
      neg_res_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      dbz_q       <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      opb_q       <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      tag_q       <= '0;
      dbz_out_q   <= 1'b0;
    end else if (start_accept) begin
      is_div_q  <= in_div;
      neg_res_q <= a_neg ^ b_neg;
      neg_rem_q <= a_neg && in_div;
      dbz_q     <= in_dbz;
      hi_q      <= '0;
      lo_q      <= in_div ? a_mag : b_mag;
      opb_q     <= in_div ? b_mag : a_mag;
      tag_q     <= TagIn;
      dbz_out_q <= 1'b0;
      if (early) begin
        result_q    <= in_dbz ? '1 : '0;
        result_hi_q <= in_dbz ? Operand1 : '0;
        dbz_out_q   <= in_dbz;
      end
    end else if (state_q == StRun) begin
      hi_q <= iter_hi;
      lo_q <= iter_lo;
      if (finish) begin
        result_q    <= fix_lo;
        result_hi_q <= fix_hi;
        dbz_out_q   <= dbz_q;
      end
    end
  end

  assign Busy      = (state_q == StRun);
  assign Done      = (state_q == StDone);
  assign Result    = result_q;
  assign ResultHi  = result_hi_q;
  assign TagOut    = tag_q;
  assign DivByZero = dbz_out_q;

endmodule
